alarm_multi_ctrl: RTL

//  Next-generation alarm controller with NUM_ALARMS independent alarm channels.

---
 rtl/alarm_multi_ctrl_if.sv | 31 +++
 rtl/alarm_multi_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alarm_multi_ctrl_if.sv
// Interface bundling the alarm settings, current time, buttons and LED outputs
// of alarm_multi_ctrl.
//   master : drives settings/time/buttons, observes LEDs (time-keeping side / bench)
//   slave  : the alarm controller itself
interface alarm_multi_ctrl_if #(
  parameter int NUM_ALARMS = 4
);
  logic [6*NUM_ALARMS-1:0] alarm_hour;
  logic [6*NUM_ALARMS-1:0] alarm_min;
  logic [NUM_ALARMS-1:0]   alarm_en;
  logic [5:0]              current_hour;
  logic [5:0]              current_min;
  logic                    snooze_btn;
  logic                    dismiss_btn;
  logic [NUM_ALARMS-1:0]   alarm_enable_LED;
  logic                    alarm_LED;
  logic [2:0]              active_id;
  logic                    snooze_led;

  modport master (
    output alarm_hour, alarm_min, alarm_en, current_hour, current_min,
           snooze_btn, dismiss_btn,
    input  alarm_enable_LED, alarm_LED, active_id, snooze_led
  );

  modport slave (
    input  alarm_hour, alarm_min, alarm_en, current_hour, current_min,
           snooze_btn, dismiss_btn,
    output alarm_enable_LED, alarm_LED, active_id, snooze_led
  );
endinterface

// File: rtl/alarm_multi_ctrl.sv
// Multi-channel alarm controller. Each channel has its own IDLE/RINGING/SNOOZED
// FSM driven by minute edges of the external time-keeping counter, with a
// per-event snooze limit and a global dismiss.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   bus  - alarm_multi_ctrl_if.slave:
//          alarm_hour/alarm_min (6 bits per channel), alarm_en, current_hour,
//          current_min, snooze_btn, dismiss_btn in;
//          alarm_enable_LED, alarm_LED, active_id, snooze_led out (all registered)
module alarm_multi_ctrl #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_MIN   = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic               clk,
  input  logic               rst,
  alarm_multi_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  localparam logic [3:0] RING_LD = 4'(RING_MIN);
  localparam logic [3:0] SNZ_LD  = 4'(SNOOZE_MIN);
  localparam logic [2:0] MAX_CNT = 3'(MAX_SNOOZE);

  state_t          state     [NUM_ALARMS];
  state_t          state_nxt [NUM_ALARMS];
  logic [3:0]      timer     [NUM_ALARMS];
  logic [3:0]      timer_nxt [NUM_ALARMS];
  logic [2:0]      cnt       [NUM_ALARMS];
  logic [2:0]      cnt_nxt   [NUM_ALARMS];

  logic [5:0]            prev_min;
  logic                  prev_vld;
  logic                  min_edge;
  logic [NUM_ALARMS-1:0] match;

  logic       ring_any;
  logic       snz_any;
  logic [2:0] id_nxt;

  // prev_vld suppresses the edge in the first cycle after reset, so releasing
  // reset while the time already equals an alarm setting never rings.
  always_comb begin
    min_edge = prev_vld && (bus.current_min != prev_min);
  end

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      state_nxt[i] = state[i];
      timer_nxt[i] = timer[i];
      cnt_nxt[i]   = cnt[i];
      match[i] = min_edge && bus.alarm_en[i] &&
                 (bus.current_hour == bus.alarm_hour[6*i +: 6]) &&
                 (bus.current_min  == bus.alarm_min[6*i +: 6]);

      if (!bus.alarm_en[i]) begin
        state_nxt[i] = IDLE;
      end else begin
        unique case (state[i])
          IDLE: begin
            if (match[i]) begin
              state_nxt[i] = RINGING;
              timer_nxt[i] = RING_LD;
              cnt_nxt[i]   = '0;
            end
          end
          RINGING: begin
            if (bus.dismiss_btn) begin
              state_nxt[i] = IDLE;
            end else if (bus.snooze_btn && (cnt[i] < MAX_CNT)) begin
              state_nxt[i] = SNOOZED;
              timer_nxt[i] = SNZ_LD;
              cnt_nxt[i]   = cnt[i] + 3'd1;
            end else if (min_edge) begin
              // An exhausted snooze press is ignored, so the timer still runs.
              if (timer[i] == 4'd1) state_nxt[i] = IDLE;
              else                  timer_nxt[i] = timer[i] - 4'd1;
            end
          end
          SNOOZED: begin
            if (bus.dismiss_btn) begin
              state_nxt[i] = IDLE;
            end else if (min_edge) begin
              if (timer[i] == 4'd1) begin
                state_nxt[i] = RINGING;
                timer_nxt[i] = RING_LD;
              end else begin
                timer_nxt[i] = timer[i] - 4'd1;
              end
            end
          end
          default: state_nxt[i] = IDLE;
        endcase
      end
    end
  end

  // Outputs are derived from the next state so the LEDs change on the same
  // clock edge as the channel state.
  always_comb begin
    ring_any = 1'b0;
    snz_any  = 1'b0;
    id_nxt   = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (state_nxt[i] == RINGING && !ring_any) id_nxt = 3'(i);
      if (state_nxt[i] == RINGING) ring_any = 1'b1;
      if (state_nxt[i] == SNOOZED) snz_any  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
        cnt[i]   <= '0;
      end
      prev_min             <= '0;
      prev_vld             <= 1'b0;
      bus.alarm_enable_LED <= '0;
      bus.alarm_LED        <= 1'b0;
      bus.active_id        <= '0;
      bus.snooze_led       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        state[i] <= state_nxt[i];
        timer[i] <= timer_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      prev_min             <= bus.current_min;
      prev_vld             <= 1'b1;
      bus.alarm_enable_LED <= bus.alarm_en;
      bus.alarm_LED        <= ring_any;
      bus.active_id        <= id_nxt;
      bus.snooze_led       <= snz_any && !ring_any;
    end
  end

endmodule
